bpred_dual_mem: RTL and testbench

//   Storage block for the branch-predictor front end. It holds two independent simple-dual-port synchronous RAMs.

---
 rtl/bpred_dual_mem_if.sv | 30 +++
 rtl/bpred_dual_mem.sv | 38 +++
 tb/tb_bpred_dual_mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bpred_dual_mem_if.sv
// bpred_dual_mem_if: write/read bus for the instruction and predictor RAMs
interface bpred_dual_mem_if #(
  parameter int IM_AW = 8,
  parameter int IM_DW = 32,
  parameter int PM_AW = 8,
  parameter int PM_LANES = 4,
  parameter int PM_LW = 9
);
  logic                      im_wren;
  logic [IM_AW-1:0]          im_wraddress;
  logic [IM_DW-1:0]          im_data;
  logic [IM_AW-1:0]          im_rdaddress;
  logic [IM_DW-1:0]          im_q;
  logic                      pm_wren;
  logic [PM_LANES-1:0]       pm_byteena;
  logic [PM_AW-1:0]          pm_wraddress;
  logic [PM_LANES*PM_LW-1:0] pm_data;
  logic [PM_AW-1:0]          pm_rdaddress;
  logic [PM_LANES*PM_LW-1:0] pm_q;
  modport master (
    output im_wren, im_wraddress, im_data, im_rdaddress,
    output pm_wren, pm_byteena, pm_wraddress, pm_data, pm_rdaddress,
    input  im_q, pm_q
  );
  modport slave (
    input  im_wren, im_wraddress, im_data, im_rdaddress,
    input  pm_wren, pm_byteena, pm_wraddress, pm_data, pm_rdaddress,
    output im_q, pm_q
  );
endinterface

// File: rtl/bpred_dual_mem.sv
// bpred_dual_mem: two independent simple-dual-port RAMs with registered, read-old-data outputs
module bpred_dual_mem #(
  parameter int IM_AW = 8,
  parameter int IM_DW = 32,
  parameter int PM_AW = 8,
  parameter int PM_LANES = 4,
  parameter int PM_LW = 9
) (
  input logic clk,
  input logic reset,
  bpred_dual_mem_if.slave bus
);
  localparam int PM_DW = PM_LANES * PM_LW;
  logic [IM_DW-1:0] im_mem [2**IM_AW];
  logic [PM_DW-1:0] pm_mem [2**PM_AW];
  logic [IM_DW-1:0] im_q_d, im_q_q;
  logic [PM_DW-1:0] pm_q_d, pm_q_q;
  always_comb begin
    im_q_d = im_mem[bus.im_rdaddress];
    pm_q_d = pm_mem[bus.pm_rdaddress];
  end
  always_ff @(posedge clk)
    if (bus.im_wren) im_mem[bus.im_wraddress] <= bus.im_data;
  always_ff @(posedge clk)
    if (bus.pm_wren)
      for (int k = 0; k < PM_LANES; k++)
        if (bus.pm_byteena[k]) pm_mem[bus.pm_wraddress][k*PM_LW +: PM_LW] <= bus.pm_data[k*PM_LW +: PM_LW];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      im_q_q <= '0;
      pm_q_q <= '0;
    end else begin
      im_q_q <= im_q_d;
      pm_q_q <= pm_q_d;
    end
  assign bus.im_q = im_q_q;
  assign bus.pm_q = pm_q_q;
endmodule

// File: tb/tb_bpred_dual_mem.sv
// tb_bpred_dual_mem: directed self-checking bench for bpred_dual_mem
module tb_bpred_dual_mem;
  logic clk = 0;
  logic reset = 0;
  int tests = 0;
  int fails = 0;
  bpred_dual_mem_if bus();
  bpred_dual_mem dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.im_wren = 0;
    bus.pm_wren = 0;
    bus.pm_byteena = 4'b0000;
  endtask
  task automatic im_wr(input logic [7:0] a, input logic [31:0] d);
    bus.im_wren = 1;
    bus.im_wraddress = a;
    bus.im_data = d;
  endtask
  task automatic pm_wr(input logic [7:0] a, input logic [35:0] d, input logic [3:0] be);
    bus.pm_wren = 1;
    bus.pm_wraddress = a;
    bus.pm_data = d;
    bus.pm_byteena = be;
  endtask
  task automatic test_reset();
    #1;
    tests++;
    if (bus.im_q !== 32'h0) begin fails++; $display("FAIL reset_im: got %h want %h", bus.im_q, 32'h0); end
    tests++;
    if (bus.pm_q !== 36'h0) begin fails++; $display("FAIL reset_pm: got %h want %h", bus.pm_q, 36'h0); end
    tick();
    reset = 1;
  endtask
  task automatic test_im_write();
    im_wr(8'h05, 32'hDEADBEEF);
    tick();
    idle();
    bus.im_rdaddress = 8'h05;
    tick();
    tests++;
    if (bus.im_q !== 32'hDEADBEEF) begin fails++; $display("FAIL im_write: got %h want %h", bus.im_q, 32'hDEADBEEF); end
  endtask
  task automatic test_pm_lanes();
    pm_wr(8'h10, 36'h9ABCD1234, 4'b1111);
    tick();
    pm_wr(8'h10, 36'h0000001FF, 4'b0001);
    tick();
    idle();
    bus.pm_rdaddress = 8'h10;
    tick();
    tests++;
    if (bus.pm_q !== 36'h9ABCD13FF) begin fails++; $display("FAIL pm_lane0: got %h want %h", bus.pm_q, 36'h9ABCD13FF); end
    pm_wr(8'h10, 36'hFFFFFFFFF, 4'b1000);
    tick();
    idle();
    tick();
    tests++;
    if (bus.pm_q !== 36'hFFBCD13FF) begin fails++; $display("FAIL pm_lane3: got %h want %h", bus.pm_q, 36'hFFBCD13FF); end
  endtask
  task automatic test_rdw();
    im_wr(8'h20, 32'h0);
    tick();
    im_wr(8'h20, 32'hFFFFFFFF);
    bus.im_rdaddress = 8'h20;
    pm_wr(8'h10, 36'h0, 4'b0010);
    bus.pm_rdaddress = 8'h10;
    tick();
    idle();
    tests++;
    if (bus.im_q !== 32'h0) begin fails++; $display("FAIL rdw_im_old: got %h want %h", bus.im_q, 32'h0); end
    tests++;
    if (bus.pm_q !== 36'hFFBCD13FF) begin fails++; $display("FAIL rdw_pm_old: got %h want %h", bus.pm_q, 36'hFFBCD13FF); end
    tick();
    tests++;
    if (bus.im_q !== 32'hFFFFFFFF) begin fails++; $display("FAIL rdw_im_new: got %h want %h", bus.im_q, 32'hFFFFFFFF); end
    tests++;
    if (bus.pm_q !== 36'hFFBCC01FF) begin fails++; $display("FAIL rdw_pm_new: got %h want %h", bus.pm_q, 36'hFFBCC01FF); end
  endtask
  task automatic test_async_reset();
    bus.im_rdaddress = 8'h05;
    tick();
    tests++;
    if (bus.im_q !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_reset_im: got %h want %h", bus.im_q, 32'hDEADBEEF); end
    #1;
    reset = 0;
    #1;
    tests++;
    if (bus.im_q !== 32'h0) begin fails++; $display("FAIL async_clr_im: got %h want %h", bus.im_q, 32'h0); end
    tests++;
    if (bus.pm_q !== 36'h0) begin fails++; $display("FAIL async_clr_pm: got %h want %h", bus.pm_q, 36'h0); end
    im_wr(8'h30, 32'h12345678);
    tick();
    idle();
    tests++;
    if (bus.im_q !== 32'h0) begin fails++; $display("FAIL reset_hold_im: got %h want %h", bus.im_q, 32'h0); end
    reset = 1;
    tick();
    tests++;
    if (bus.im_q !== 32'hDEADBEEF) begin fails++; $display("FAIL retain_im: got %h want %h", bus.im_q, 32'hDEADBEEF); end
    tests++;
    if (bus.pm_q !== 36'hFFBCC01FF) begin fails++; $display("FAIL retain_pm: got %h want %h", bus.pm_q, 36'hFFBCC01FF); end
    bus.im_rdaddress = 8'h30;
    tick();
    tests++;
    if (bus.im_q !== 32'h12345678) begin fails++; $display("FAIL write_in_reset: got %h want %h", bus.im_q, 32'h12345678); end
  endtask
  task automatic test_independent();
    im_wr(8'h02, 32'hA5A5A5A5);
    tick();
    im_wr(8'h01, 32'h11111111);
    bus.im_rdaddress = 8'h02;
    tick();
    idle();
    tests++;
    if (bus.im_q !== 32'hA5A5A5A5) begin fails++; $display("FAIL diff_addr_rd: got %h want %h", bus.im_q, 32'hA5A5A5A5); end
    bus.im_rdaddress = 8'h01;
    tick();
    tests++;
    if (bus.im_q !== 32'h11111111) begin fails++; $display("FAIL diff_addr_wr: got %h want %h", bus.im_q, 32'h11111111); end
    pm_wr(8'h10, 36'h000000000, 4'b0000);
    bus.pm_rdaddress = 8'h10;
    tick();
    idle();
    tick();
    tests++;
    if (bus.pm_q !== 36'hFFBCC01FF) begin fails++; $display("FAIL be_zero: got %h want %h", bus.pm_q, 36'hFFBCC01FF); end
  endtask
  function automatic logic [35:0] pat(input logic [7:0] a);
    return {a, ~a, a, ~a, a[3:0]};
  endfunction
  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      pm_wr(8'(a), pat(8'(a)), 4'b1111);
      tick();
    end
    idle();
    bus.pm_rdaddress = 8'h00;
    for (int a = 0; a < 256; a++) begin
      tick();
      tests++;
      if (bus.pm_q !== pat(8'(a))) begin fails++; $display("FAIL sweep[%0d]: got %h want %h", a, bus.pm_q, pat(8'(a))); end
      bus.pm_rdaddress = 8'(a + 1);
    end
  endtask
  initial begin
    idle();
    bus.im_wraddress = 0;
    bus.im_data = 0;
    bus.im_rdaddress = 0;
    bus.pm_wraddress = 0;
    bus.pm_data = 0;
    bus.pm_rdaddress = 0;
    test_reset();
    test_im_write();
    test_pm_lanes();
    test_rdw();
    test_async_reset();
    test_independent();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
